alu_result_serializer: RTL

- Transmit side of the ALU serial output protocol: takes one ALU result word, flags or error code and drives it on a single serial line `sout`.
- Builds the CRC-3 or parity itself and frames the bytes into 11-bit packets.
- Sits at the ALU output stage. It is the exact counterpart of the bench's packet reader.

---
 rtl/alu_result_serializer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - serial transmitter for ALU result / flags / error frames
//
// Purpose:
//   Takes one ALU result word (C), its flags, or an error code, and sends it on
//   a single registered serial line. Every packet is 11 bits long:
//   start(0), type(DATA=0/CTL=1), 8 payload bits MSB first, stop(1).
//   A normal result goes out as 4 DATA packets (C MSB byte first) followed by
//   one CTL packet {0, flags, crc3}. An error code goes out as a single CTL
//   packet {1, ef, even-parity bit}.
//
// Ports:
//   clk    in   system clock; sout changes only on its rising edge
//   rst_n  in   asynchronous active-low reset; aborts any frame at once
//   req    in   transaction request, accepted when req && ready
//   ready  out  high only while idle
//   C      in   32-bit ALU result, sampled on accept
//   flags  in   {Carry, Overflow, Zero, Negative}, sampled on accept
//   err    in   {data_err, crc_err, op_err}, sampled on accept
//   sout   out  serial line (registered)
//   done   out  one-cycle pulse in the first idle cycle after the last stop bit

module alu_result_serializer #(
  parameter int   DATA_BYTES = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ready,
  input  logic [31:0] C,
  input  logic [3:0]  flags,
  input  logic [2:0]  err,
  output logic        sout,
  output logic        done
);

  // Index of the CTL packet in a normal frame; an error frame has only packet 0.
  localparam logic [2:0] LAST_NORMAL = 3'(DATA_BYTES);

  // The state names what is on the line during the current cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TYPE,
    S_DATA,
    S_STOP
  } state_t;

  state_t      state_q;
  logic        sout_q;
  logic        ready_q;
  logic        done_q;
  logic [2:0]  bit_cnt_q;
  logic [2:0]  pkt_cnt_q;
  logic [2:0]  last_q;
  logic [7:0]  shift_q;
  logic [31:0] c_q;
  logic [7:0]  ctl_byte_q;

  logic        err_any_d;
  logic [5:0]  ef_d;
  logic [7:0]  err_byte_d;
  logic [2:0]  crc_d;
  logic [7:0]  ctl_byte_d;
  logic [2:0]  pkt_next_d;
  logic [7:0]  next_byte_d;

  // CRC-3, x^3+x+1, init 0, MSB of d shifted in first.
  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] r;
    logic       fb;
    r = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = r[2] ^ d[i];
      r  = {r[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return r;
  endfunction

  // Byte idx of the result word, idx 0 being the most significant byte.
  function automatic logic [7:0] data_byte(input logic [31:0] c, input logic [2:0] idx);
    logic [31:0] s;
    s = c << (8 * idx);
    return s[31:24];
  endfunction

  // Error code selection, highest bit wins.
  always_comb begin
    err_any_d = |err;
    ef_d      = 6'b000000;
    if (err[2]) begin
      ef_d = 6'b100100;
    end else if (err[1]) begin
      ef_d = 6'b010010;
    end else if (err[0]) begin
      ef_d = 6'b001001;
    end
    // Trailing bit makes the whole error byte even parity.
    err_byte_d = {1'b1, ef_d, ^{1'b1, ef_d}};
  end

  // CRC is computed in parallel at accept time so it is ready long before CTL.
  always_comb begin
    crc_d      = crc3({C, 1'b0, flags});
    ctl_byte_d = err_any_d ? err_byte_d : {1'b0, flags, crc_d};
  end

  // Payload for the packet that follows the current one.
  always_comb begin
    pkt_next_d  = pkt_cnt_q + 3'd1;
    next_byte_d = (pkt_next_d == last_q) ? ctl_byte_q : data_byte(c_q, pkt_next_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sout_q     <= IDLE_LEVEL;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      pkt_cnt_q  <= 3'd0;
      last_q     <= 3'd0;
      shift_q    <= 8'h00;
      c_q        <= 32'h0;
      ctl_byte_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sout_q  <= IDLE_LEVEL;
          ready_q <= 1'b1;
          if (req && ready_q) begin
            c_q        <= C;
            ctl_byte_q <= ctl_byte_d;
            last_q     <= err_any_d ? 3'd0 : LAST_NORMAL;
            pkt_cnt_q  <= 3'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= err_any_d ? err_byte_d : C[31:24];
            sout_q     <= 1'b0;
            ready_q    <= 1'b0;
            state_q    <= S_START;
          end
        end

        S_START: begin
          // Only the final packet of a frame is a CTL packet.
          sout_q  <= (pkt_cnt_q == last_q);
          state_q <= S_TYPE;
        end

        S_TYPE: begin
          sout_q    <= shift_q[7];
          shift_q   <= {shift_q[6:0], 1'b0};
          bit_cnt_q <= 3'd0;
          state_q   <= S_DATA;
        end

        S_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            sout_q  <= IDLE_LEVEL;
            state_q <= S_STOP;
          end else begin
            sout_q    <= shift_q[7];
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end

        S_STOP: begin
          if (pkt_cnt_q < last_q) begin
            sout_q    <= 1'b0;
            pkt_cnt_q <= pkt_next_d;
            shift_q   <= next_byte_d;
            state_q   <= S_START;
          end else begin
            sout_q  <= IDLE_LEVEL;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        default: begin
          sout_q  <= IDLE_LEVEL;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sout  = sout_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule
